// File: rtl/seg7_disp_ctrl.sv
// seg7_disp_ctrl: multi-digit 7-segment display controller.
// Shows a hex value directly, or converts an unsigned binary value to decimal
// (one bit per cycle, shift-add-3), with leading-zero blanking, an overflow
// dash pattern and per-digit blinking.
// Ports:
//   iCLK, iRST         clock, synchronous active-high reset
//   iDATA [4N-1:0]     value to show, sampled when a load is accepted
//   iLOAD              load request, accepted when oBUSY is low
//   iDEC               1 = decimal conversion, 0 = hex
//   iLZB               leading-zero blanking enable
//   iBLINK [N-1:0]     live per-digit blink mask
//   oSEG [7N-1:0]      registered active-low segments, digit 0 rightmost
//   oBUSY              decimal conversion in progress
//   oOVF               last accepted decimal value did not fit
module seg7_disp_ctrl #(
    parameter int NUM_DIG   = 6,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [4*NUM_DIG-1:0]   iDATA,
    input  logic                   iLOAD,
    input  logic                   iDEC,
    input  logic                   iLZB,
    input  logic [NUM_DIG-1:0]     iBLINK,
    output logic [7*NUM_DIG-1:0]   oSEG,
    output logic                   oBUSY,
    output logic                   oOVF
);

    localparam int W  = 4 * NUM_DIG;
    localparam int NW = $clog2(W);
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] MAXV = pow10(NUM_DIG) - 64'd1;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0011000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    typedef enum logic {
        S_IDLE,
        S_CONV
    } state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         bin_q, bin_d;
    logic [W-1:0]         bcd_q, bcd_d;
    logic [NW-1:0]        cnt_q, cnt_d;
    logic                 povf_q, povf_d;
    logic                 plzb_q, plzb_d;
    logic [W-1:0]         dig_q, dig_d;
    logic                 lzb_q, lzb_d;
    logic                 ovf_q, ovf_d;
    logic                 shown_q, shown_d;
    logic [CW-1:0]        bcnt_q, bcnt_d;
    logic                 phase_q, phase_d;
    logic [7*NUM_DIG-1:0] seg_q, seg_d;

    logic [W-1:0]         bcd_adj;
    logic [W-1:0]         bcd_sh;
    logic [63:0]          data64;

    assign data64 = 64'(iDATA);

    // One double-dabble step: correct each BCD digit, then shift in the
    // next binary bit (MSB first).
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_sh = {bcd_adj[W-2:0], bin_q[W-1]};
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        povf_d  = povf_q;
        plzb_d  = plzb_q;
        dig_d   = dig_q;
        lzb_d   = lzb_q;
        ovf_d   = ovf_q;
        shown_d = shown_q;

        case (state_q)
            S_IDLE: begin
                if (iLOAD) begin
                    if (iDEC) begin
                        state_d = S_CONV;
                        bin_d   = iDATA;
                        bcd_d   = '0;
                        cnt_d   = '0;
                        povf_d  = (data64 > MAXV);
                        plzb_d  = iLZB;
                    end else begin
                        dig_d   = iDATA;
                        lzb_d   = iLZB;
                        ovf_d   = 1'b0;
                        shown_d = 1'b1;
                    end
                end
            end
            S_CONV: begin
                bin_d = bin_q << 1;
                bcd_d = bcd_sh;
                cnt_d = cnt_q + NW'(1);
                if (cnt_q == NW'(W - 1)) begin
                    state_d = S_IDLE;
                    dig_d   = bcd_sh;
                    lzb_d   = plzb_q;
                    ovf_d   = povf_q;
                    shown_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bcnt_d  = bcnt_q + CW'(1);
        phase_d = phase_q;
        if (bcnt_q == CW'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end
    end

    // Segment image; the display stays dark until a value has been shown
    // since reset, so an aborted conversion leaves it blank.
    always_comb begin
        logic       lead;
        logic [6:0] g;
        seg_d = '1;
        lead  = 1'b1;
        g     = SEG_BLANK;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            lead = lead & (dig_q[4*i +: 4] == 4'd0);
            g    = ovf_q ? SEG_DASH : glyph(dig_q[4*i +: 4]);
            if (!ovf_q && lzb_q && lead && (i != 0)) begin
                g = SEG_BLANK;
            end
            if (phase_q && iBLINK[i]) begin
                g = SEG_BLANK;
            end
            if (!shown_q) begin
                g = SEG_BLANK;
            end
            seg_d[7*i +: 7] = g;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            povf_q  <= 1'b0;
            plzb_q  <= 1'b0;
            dig_q   <= '0;
            lzb_q   <= 1'b0;
            ovf_q   <= 1'b0;
            shown_q <= 1'b0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            seg_q   <= '1;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            povf_q  <= povf_d;
            plzb_q  <= plzb_d;
            dig_q   <= dig_d;
            lzb_q   <= lzb_d;
            ovf_q   <= ovf_d;
            shown_q <= shown_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
            seg_q   <= seg_d;
        end
    end

    assign oSEG  = seg_q;
    assign oBUSY = (state_q == S_CONV);
    assign oOVF  = ovf_q;

endmodule

// File: tb/tb_seg7_disp_ctrl.sv
// tb_seg7_disp_ctrl: directed, table-driven bench for seg7_disp_ctrl
// (NUM_DIG = 6, BLINK_DIV = 4).
module tb_seg7_disp_ctrl;

    logic        iCLK;
    logic        iRST;
    logic [23:0] iDATA;
    logic        iLOAD;
    logic        iDEC;
    logic        iLZB;
    logic [5:0]  iBLINK;
    logic [41:0] oSEG;
    logic        oBUSY;
    logic        oOVF;

    int checks = 0;
    int errors = 0;

    seg7_disp_ctrl #(
        .NUM_DIG   (6),
        .BLINK_DIV (4)
    ) dut (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iDATA  (iDATA),
        .iLOAD  (iLOAD),
        .iDEC   (iDEC),
        .iLZB   (iLZB),
        .iBLINK (iBLINK),
        .oSEG   (oSEG),
        .oBUSY  (oBUSY),
        .oOVF   (oOVF)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    localparam logic [4:0] B  = 5'd16;
    localparam logic [4:0] DS = 5'd17;

    typedef struct {
        logic [23:0] data;
        logic        dec;
        logic        lzb;
        logic [29:0] codes;
        logic        ovf;
    } vec_t;

    vec_t vecs[17];

    function automatic logic [6:0] gl(input logic [4:0] c);
        logic [6:0] g;
        case (c)
            5'd0:  g = 7'b1000000;
            5'd1:  g = 7'b1111001;
            5'd2:  g = 7'b0100100;
            5'd3:  g = 7'b0110000;
            5'd4:  g = 7'b0011001;
            5'd5:  g = 7'b0010010;
            5'd6:  g = 7'b0000010;
            5'd7:  g = 7'b1111000;
            5'd8:  g = 7'b0000000;
            5'd9:  g = 7'b0011000;
            5'd10: g = 7'b0001000;
            5'd11: g = 7'b0000011;
            5'd12: g = 7'b1000110;
            5'd13: g = 7'b0100001;
            5'd14: g = 7'b0000110;
            5'd15: g = 7'b0001110;
            5'd17: g = 7'b0111111;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    function automatic logic [41:0] mk(input logic [29:0] c);
        logic [41:0] s;
        for (int i = 0; i < 6; i++) begin
            s[7*i +: 7] = gl(c[5*i +: 5]);
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (oBUSY && n < 100) begin
            n++;
            @(negedge iCLK);
        end
    endtask

    task automatic run_vec(input int idx);
        int n;
        @(negedge iCLK);
        iDATA = vecs[idx].data;
        iDEC  = vecs[idx].dec;
        iLZB  = vecs[idx].lzb;
        iLOAD = 1'b1;
        @(negedge iCLK);
        iLOAD = 1'b0;
        if (vecs[idx].dec) begin
            wait_idle(n);
            chk($sformatf("v%0d_busy_cycles", idx), 64'(n), 64'd24);
        end else begin
            chk($sformatf("v%0d_busy_hex", idx), 64'(oBUSY), 64'd0);
        end
        @(negedge iCLK);
        chk($sformatf("v%0d_seg", idx), 64'(oSEG), 64'(mk(vecs[idx].codes)));
        chk($sformatf("v%0d_ovf", idx), 64'(oOVF), 64'(vecs[idx].ovf));
    endtask

    initial begin
        logic [41:0] e;
        logic [6:0]  d0;
        logic [6:0]  prev;
        int          run;
        int          nchg;
        int          n;

        vecs[0]  = '{24'h00A5F0, 1'b0, 1'b1, {B, B, 5'd10, 5'd5, 5'd15, 5'd0}, 1'b0};
        vecs[1]  = '{24'h00A5F0, 1'b0, 1'b0, {5'd0, 5'd0, 5'd10, 5'd5, 5'd15, 5'd0}, 1'b0};
        vecs[2]  = '{24'h01E240, 1'b1, 1'b0, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6}, 1'b0};
        vecs[3]  = '{24'h0F4240, 1'b1, 1'b1, {DS, DS, DS, DS, DS, DS}, 1'b1};
        vecs[4]  = '{24'h000001, 1'b0, 1'b1, {B, B, B, B, B, 5'd1}, 1'b0};
        vecs[5]  = '{24'h0F423F, 1'b1, 1'b1, {5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9}, 1'b0};
        vecs[6]  = '{24'h00002A, 1'b1, 1'b1, {B, B, B, B, 5'd4, 5'd2}, 1'b0};
        vecs[7]  = '{24'h000000, 1'b1, 1'b1, {B, B, B, B, B, 5'd0}, 1'b0};
        vecs[8]  = '{24'h000000, 1'b0, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}, 1'b0};
        vecs[9]  = '{24'hFFFFFF, 1'b0, 1'b0, {5'd15, 5'd15, 5'd15, 5'd15, 5'd15, 5'd15}, 1'b0};
        vecs[10] = '{24'hFFFFFF, 1'b1, 1'b0, {DS, DS, DS, DS, DS, DS}, 1'b1};
        vecs[11] = '{24'h000007, 1'b1, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd7}, 1'b0};
        vecs[12] = '{24'h123456, 1'b0, 1'b1, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6}, 1'b0};
        vecs[13] = '{24'h100000, 1'b0, 1'b1, {5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}, 1'b0};
        vecs[14] = '{24'h0186A0, 1'b1, 1'b1, {5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0}, 1'b0};
        vecs[15] = '{24'h0F4240, 1'b1, 1'b0, {DS, DS, DS, DS, DS, DS}, 1'b1};
        vecs[16] = '{24'h000001, 1'b0, 1'b0, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1}, 1'b0};

        iRST   = 1'b1;
        iDATA  = '0;
        iLOAD  = 1'b0;
        iDEC   = 1'b0;
        iLZB   = 1'b0;
        iBLINK = '0;
        repeat (3) @(negedge iCLK);
        chk("rst_seg", 64'(oSEG), 64'h3FF_FFFF_FFFF);
        chk("rst_busy", 64'(oBUSY), 64'd0);
        chk("rst_ovf", 64'(oOVF), 64'd0);
        iRST = 1'b0;
        repeat (4) @(negedge iCLK);
        chk("idle_seg_dark", 64'(oSEG), 64'h3FF_FFFF_FFFF);

        for (int i = 0; i < 17; i++) begin
            run_vec(i);
        end

        // Back-to-back hex loads.
        @(negedge iCLK);
        iDEC  = 1'b0;
        iLZB  = 1'b0;
        iDATA = 24'h111111;
        iLOAD = 1'b1;
        @(negedge iCLK);
        iDATA = 24'h222222;
        @(negedge iCLK);
        iLOAD = 1'b0;
        e = mk({5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1});
        chk("b2b_first", 64'(oSEG), 64'(e));
        @(negedge iCLK);
        e = mk({5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2});
        chk("b2b_second", 64'(oSEG), 64'(e));

        // Load held high through a decimal conversion.
        iDEC  = 1'b1;
        iLZB  = 1'b0;
        iDATA = 24'h01E240;
        iLOAD = 1'b1;
        @(negedge iCLK);
        chk("hold_busy_start", 64'(oBUSY), 64'd1);
        iDATA = 24'h00002A;
        @(negedge iCLK);
        iLZB  = 1'b1;
        wait_idle(n);
        chk("hold_busy_cycles", 64'(n + 1), 64'd24);
        @(negedge iCLK);
        iLOAD = 1'b0;
        chk("hold_reaccept", 64'(oBUSY), 64'd1);
        e = mk({5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6});
        chk("hold_first_res", 64'(oSEG), 64'(e));
        wait_idle(n);
        @(negedge iCLK);
        e = mk({B, B, B, B, 5'd4, 5'd2});
        chk("hold_second_res", 64'(oSEG), 64'(e));

        // Blink on digit 0 with a 4-cycle half-period.
        iDEC  = 1'b0;
        iLZB  = 1'b0;
        iDATA = 24'h123456;
        iLOAD = 1'b1;
        @(negedge iCLK);
        iLOAD  = 1'b0;
        iBLINK = 6'b000001;
        repeat (2) @(negedge iCLK);
        e    = mk({5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6});
        prev = oSEG[6:0];
        run  = 0;
        nchg = 0;
        for (int c = 0; c < 20; c++) begin
            d0 = oSEG[6:0];
            chk("blink_d0_val",
                64'((d0 == 7'b0000010) || (d0 == 7'b1111111)), 64'd1);
            chk("blink_upper", 64'(oSEG[41:7]), 64'(e[41:7]));
            if (d0 != prev) begin
                if (nchg > 0) begin
                    chk("blink_run", 64'(run), 64'd4);
                end
                nchg++;
                run = 1;
            end else begin
                run++;
            end
            prev = d0;
            @(negedge iCLK);
        end
        chk("blink_toggles", 64'(nchg >= 3), 64'd1);
        iBLINK = '0;

        // Reset in the middle of a decimal conversion.
        iDEC  = 1'b1;
        iDATA = 24'h01E240;
        iLOAD = 1'b1;
        @(negedge iCLK);
        iLOAD = 1'b0;
        repeat (9) @(negedge iCLK);
        chk("abort_busy_pre", 64'(oBUSY), 64'd1);
        iRST = 1'b1;
        @(negedge iCLK);
        chk("abort_busy", 64'(oBUSY), 64'd0);
        chk("abort_seg", 64'(oSEG), 64'h3FF_FFFF_FFFF);
        chk("abort_ovf", 64'(oOVF), 64'd0);
        iRST = 1'b0;
        repeat (30) @(negedge iCLK);
        chk("abort_seg_later", 64'(oSEG), 64'h3FF_FFFF_FFFF);
        chk("abort_busy_later", 64'(oBUSY), 64'd0);

        // Load on the first edge after reset is released.
        iRST = 1'b1;
        @(negedge iCLK);
        iRST  = 1'b0;
        iDEC  = 1'b0;
        iLZB  = 1'b0;
        iDATA = 24'h000042;
        iLOAD = 1'b1;
        @(negedge iCLK);
        iLOAD = 1'b0;
        @(negedge iCLK);
        e = mk({5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd2});
        chk("post_rst_load", 64'(oSEG), 64'(e));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_disp_ctrl.md
SEG7_DISP_CTRL -- requirements
Module: seg7_disp_ctrl

Interface
REQ-001 Parameter NUM_DIG, default 6, number of 7-segment digits driven (1..8).
REQ-002 Parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (>=2).
REQ-003 Derived constant W = 4*NUM_DIG, the input value width.
REQ-004 iCLK  input  1  clock; the single clock for all logic.
REQ-005 iRST  input  1  reset; synchronous, active-high.
REQ-006 iDATA  input  W  value to display, sampled on load acceptance.
REQ-007 iLOAD  input  1  load request; accepted on a rising iCLK edge when iLOAD=1 and oBUSY=0.
REQ-008 iDEC  input  1  mode, sampled on acceptance: 1 = unsigned decimal, 0 = hex.
REQ-009 iLZB  input  1  leading-zero blanking enable, sampled on acceptance.
REQ-010 iBLINK  input  NUM_DIG  live per-digit blink mask; bit i selects digit i.
REQ-011 oSEG  output  7*NUM_DIG  registered active-low segments; digit i (0 = rightmost) occupies [7i+6:7i]; bit 0 = top, 1 = upper-right, 2 = lower-right, 3 = bottom, 4 = lower-left, 5 = upper-left, 6 = middle.
REQ-012 oBUSY  output  1  decimal conversion in progress; loads ignored while high.
REQ-013 oOVF  output  1  last accepted decimal value exceeded 10^NUM_DIG-1.

Function
REQ-014 Glyphs, hex digits 0-F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110; blank = 1111111; dash = 0111111.
REQ-015 An internal digit register D (NUM_DIG nibbles), plus stored iLZB and overflow flag, determines display content.
REQ-016 Hex mode: load accepted at edge k -> D = iDATA written at edge k; oBUSY stays 0.
REQ-017 Decimal mode: load accepted at edge k -> oBUSY = 1 after edge k through edge k+W-1, falling at edge k+W; sequential shift-add-3 (double-dabble) conversion, one input bit per cycle, MSB first; D written with the BCD result at edge k+W.
REQ-018 Decimal overflow: if iDATA > 10^NUM_DIG-1 at acceptance, oOVF = 1 from edge k+W, D content is don't-care, and all digits show dash; latency identical to a non-overflow conversion.
REQ-019 oOVF cleared at the completion edge of any non-overflow decimal load, or at the acceptance edge of any hex load.
REQ-020 oSEG updates on the edge following any change of D, stored flags, iBLINK or blink phase (one-cycle registered latency).
REQ-021 Leading-zero blanking (stored iLZB = 1): digit i blank when D[i] and every higher digit are 0; digit 0 is never blanked; not applied to dashes.
REQ-022 Blink: free-running counter 0..BLINK_DIV-1; phase toggles when the counter wraps; phase 0 = visible, phase 1 = digits with iBLINK[i] = 1 blank (dashes included).
REQ-023 iLOAD while oBUSY = 1 ignored, no queuing; iLOAD high on the completion edge also ignored; iDATA/iDEC/iLZB changes during conversion have no effect.
REQ-024 Back-to-back hex loads on consecutive cycles are each accepted.

Reset
REQ-025 iRST = 1 at an edge: oSEG all ones (all blank), oBUSY = 0, oOVF = 0, D = 0, stored iLZB = 0, blink counter = 0, blink phase = 0.
REQ-026 Reset mid-conversion aborts it; no partial result written; first load accepted on the first edge with iRST = 0.

Verification
REQ-027 NUM_DIG = 6, decimal load 123456 (0x01E240) -> oBUSY high 24 cycles; oSEG digits 5..0 = 1, 2, 3, 4, 5, 6 one cycle after oBUSY falls; oOVF = 0.
REQ-028 Hex load 0x00A5F0, iLZB = 1 -> digits 5, 4 blank; digits 3..0 = A, 5, F, 0; with iLZB = 0, digits 5, 4 = 0.
REQ-029 Decimal load 1000000 (NUM_DIG = 6) -> oOVF = 1, all six digits = 0111111 after 24 busy cycles; then hex load 0x000001 -> oOVF = 0.
REQ-030 BLINK_DIV = 4, iBLINK = 6'b000001 -> digit 0 alternates visible/blank every 4 cycles; other digits steady.
REQ-031 Assert iRST at cycle 10 of a decimal conversion -> oBUSY = 0 and oSEG all blank after that edge; no later update until a new load.
REQ-032 iLOAD held high throughout a decimal conversion -> only the first load accepted; next acceptance on the first edge after oBUSY is low.
